systolic_drain: RTL and testbench
=================================

# systolic_drain

Result drain engine for the `systolic_array` output matrix. Armed by a start pulse, it waits until the array's enable counter reaches a programmed target. It then reads the active N×N window of 32-bit accumulators in row-major order, requantizes each to 8 bits, and streams them out on a valid/ready interface. After the last element is accepted it pulses `clr` back into the array, so the array is ready for the next tile.

## Interface
- `ARRAY_SIZE`, 16, array dimension
- `DATA_WIDTH`, 8, operand and output element width
- `ACC_WIDTH`, 4*DATA_WIDTH, accumulator width of `O`

- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  arm pulse; sampled only in IDLE
- `activated_pe`  in  6  active window size N; sampled on accepted `start`
- `target_cnt`  in  10  `cnt` value marking compute complete; sampled on `start`
- `shift`  in  5  requant right-shift; sampled on `start`
- `cnt`  in  10  enable counter from the array
- `O`  in  signed ACC_WIDTH × [ARRAY_SIZE][ARRAY_SIZE]  array accumulators
- `clr`  out  1  one-cycle clear pulse to the array
- `out_data`  out  signed DATA_WIDTH  requantized element
- `out_row`, `out_col`  out  6 each  element coordinates
- `out_last`  out  1  marks element (N-1, N-1)
- `out_valid`  out  1  element valid
- `out_ready`  in  1  downstream accept
- `busy`  out  1  high from accepted `start` until the `clr` cycle inclusive
- `done`  out  1  one-cycle pulse coincident with `clr`

## Operation
- FSM states: IDLE, WAIT, SETTLE, STREAM, CLEAR.
- **IDLE**
  - `start` latches N, target and shift, then goes to WAIT.
  - N is clamped: N < 2 becomes 2; N > ARRAY_SIZE becomes ARRAY_SIZE.
- **WAIT**
  - Goes to SETTLE when `cnt == target`.
  - If `target_cnt == 0`, WAIT exits on the first cycle.
- **SETTLE**
  - Lasts one cycle, so the last PE's final accumulate is registered.
  - Then goes to STREAM with row = col = 0.
- **STREAM**
  - Registered output stage holds the element at (row, col).
  - On handshake (`out_valid & out_ready`), col increments. When col wraps at N-1, col returns to 0 and row increments.
  - On handshake of (N-1, N-1), goes to CLEAR.
- **CLEAR**
  - Lasts one cycle: `clr = 1`, `done = 1`, `busy = 1`.
  - Then returns to IDLE.
- Requantization per element:
  - If shift > 0, add the round constant 1 << (shift-1) at ACC_WIDTH+1 bits so it cannot overflow.
  - Arithmetic right shift by `shift`.
  - Saturate to [-128, 127].
- `start` outside IDLE is ignored.
- Reset in any state:
  - FSM returns to IDLE.
  - Counters are zeroed.
  - `clr` is not pulsed; the array owner is responsible for clearing the array.

## Timing
- Reset values: `clr`, `done`, `busy`, `out_valid`, `out_last` = 0; `out_data`, `out_row`, `out_col` = 0.
- `start` accepted at edge t:
  - `busy` = 1 from t+1.
- `cnt == target` seen at cycle w:
  - SETTLE at w+1.
  - First `out_valid` at w+2.
- Output hold: while `out_valid & !out_ready`, `out_data`, `out_row`, `out_col` and `out_last` are stable.
- Throughput: 1 element/cycle with `out_ready` held high. Minimum stream duration is N² cycles.
- Final handshake at cycle k:
  - `clr` and `done` are high at k+1.
  - `out_valid` = 0 at k+1.
  - IDLE and `busy` = 0 at k+2.
- `O` is read combinationally at the register input. The block relies on the array holding `O` stable until `clr`.

## Configuration
- `SYSTOLIC_DRAIN_RELU_EN`
  - Defined: negative results are forced to 0 after the shift and before saturation, giving output range [0, 127].
  - Undefined: signed output, range [-128, 127].

## Structure
- Package `systolic_pkg` holds:
  - state enum `drain_state_t`
  - `ACC_WIDTH` and `CNT_WIDTH` constants
  - the saturation bounds
- Sub-module `systolic_requant` implements round, shift, saturate and the optional ReLU. It is combinational and parameterized by `ACC_WIDTH` and `DATA_WIDTH`.

## Test plan
- N=2, target=0, shift=0, O = {{5, -3}, {200, -200}}, ready high:
  - Expected stream 5, -3, 127, -128.
  - `out_last` on the 4th element.
  - `clr` and `done` one cycle later.
- N=4, target=7: hold `cnt` at 6 for 10 cycles, then set it to 7.
  - No `out_valid` before cnt = 7.
  - First `out_valid` 2 cycles after.
- shift=4, O = 24 gives 2; O = -24 gives -1 (round half up); O = 7 gives 0.
- Backpressure: toggle `out_ready` every cycle.
  - All 16 elements delivered in row-major order, no duplicates.
  - Data stable while stalled.
- Assert `rst` mid-stream at element 5.
  - Next cycle: `out_valid`, `busy` and `clr` are 0.
  - A new `start` then streams from (0, 0).
- With `SYSTOLIC_DRAIN_RELU_EN` defined: O = -50 gives 0; O = 300 gives 127.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and constants for the systolic result drain.
// Holds the drain FSM state type, widths and saturation bound helpers.
package systolic_pkg;

    localparam int ACC_WIDTH = 32;
    localparam int CNT_WIDTH = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SETTLE,
        S_STREAM,
        S_CLEAR
    } drain_state_t;

    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/systolic_requant.sv
// systolic_requant: round, arithmetic shift and saturate one accumulator.
// Optional ReLU before saturation when SYSTOLIC_DRAIN_RELU_EN is defined.
module systolic_requant
    import systolic_pkg::sat_max, systolic_pkg::sat_min;
#(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [ACC_WIDTH-1:0]  i_acc,
    input  logic        [4:0]            i_shift,
    output logic signed [DATA_WIDTH-1:0] o_data
);

    localparam logic signed [ACC_WIDTH:0] MAXV =
        (ACC_WIDTH+1)'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH:0] MINV =
        (ACC_WIDTH+1)'(sat_min(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH:0] ONE =
        (ACC_WIDTH+1)'(1);

    logic signed [ACC_WIDTH:0] w_ext;
    logic signed [ACC_WIDTH:0] w_rnd;
    logic signed [ACC_WIDTH:0] w_sum;
    logic signed [ACC_WIDTH:0] w_shr;
    logic signed [ACC_WIDTH:0] w_clip;

    // One extra bit keeps the round-half-up add from overflowing
    always_comb begin
        w_ext = {i_acc[ACC_WIDTH-1], i_acc};
        w_rnd = '0;
        if (i_shift != 5'd0) begin
            w_rnd = ONE << (i_shift - 5'd1);
        end
        w_sum  = w_ext + w_rnd;
        w_shr  = w_sum >>> i_shift;
        w_clip = w_shr;
`ifdef SYSTOLIC_DRAIN_RELU_EN
        if (w_shr[ACC_WIDTH]) begin
            w_clip = '0;
        end
`endif
        o_data = w_clip[DATA_WIDTH-1:0];
        if (w_clip > MAXV) begin
            o_data = MAXV[DATA_WIDTH-1:0];
        end else if (w_clip < MINV) begin
            o_data = MINV[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: waits for compute done, streams requantized results, clears array.
// Build option: SYSTOLIC_DRAIN_RELU_EN (ReLU in systolic_requant).
module systolic_drain
    import systolic_pkg::CNT_WIDTH, systolic_pkg::drain_state_t;
#(
    parameter int ARRAY_SIZE = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 4 * DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic        [5:0]            activated_pe,
    input  logic        [CNT_WIDTH-1:0]  target_cnt,
    input  logic        [4:0]            shift,
    input  logic        [CNT_WIDTH-1:0]  cnt,
    input  logic signed [ACC_WIDTH-1:0]  O [ARRAY_SIZE][ARRAY_SIZE],
    output logic                         clr,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic        [5:0]            out_row,
    output logic        [5:0]            out_col,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done
);

    import systolic_pkg::S_IDLE;
    import systolic_pkg::S_WAIT;
    import systolic_pkg::S_SETTLE;
    import systolic_pkg::S_STREAM;
    import systolic_pkg::S_CLEAR;

    localparam int IW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam logic [5:0] N_MAX = 6'(ARRAY_SIZE);

    drain_state_t r_state;
    drain_state_t w_next;

    logic [5:0]                   r_n;
    logic [CNT_WIDTH-1:0]         r_target;
    logic [4:0]                   r_shift;
    logic [5:0]                   r_row;
    logic [5:0]                   r_col;
    logic signed [DATA_WIDTH-1:0] r_data;
    logic                         r_valid;
    logic                         r_last;

    logic [5:0]                   w_n_clamp;
    logic                         w_hs;
    logic                         w_col_end;
    logic                         w_end;
    logic [5:0]                   w_nrow;
    logic [5:0]                   w_ncol;
    logic                         w_nlast;
    logic [IW-1:0]                w_rd_row;
    logic [IW-1:0]                w_rd_col;
    logic signed [ACC_WIDTH-1:0]  w_acc;
    logic signed [DATA_WIDTH-1:0] w_q;

    // Clamp requested window into [2, ARRAY_SIZE]
    always_comb begin
        w_n_clamp = activated_pe;
        if (activated_pe < 6'd2) begin
            w_n_clamp = 6'd2;
        end else if (activated_pe > N_MAX) begin
            w_n_clamp = N_MAX;
        end
    end

    assign w_hs      = r_valid & out_ready;
    assign w_col_end = (r_col == r_n - 6'd1);
    assign w_end     = w_col_end & (r_row == r_n - 6'd1);
    assign w_ncol    = w_col_end ? 6'd0 : r_col + 6'd1;
    assign w_nrow    = w_col_end ? r_row + 6'd1 : r_row;
    assign w_nlast   = (w_nrow == r_n - 6'd1) & (w_ncol == r_n - 6'd1);

    // Read address: origin while settling, next element while streaming
    always_comb begin
        w_rd_row = w_nrow[IW-1:0];
        w_rd_col = w_ncol[IW-1:0];
        if (r_state == S_SETTLE) begin
            w_rd_row = '0;
            w_rd_col = '0;
        end
    end

    assign w_acc = O[w_rd_row][w_rd_col];

    systolic_requant #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_requant (
        .i_acc   (w_acc),
        .i_shift (r_shift),
        .o_data  (w_q)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if ((cnt == r_target) || (r_target == '0)) begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                w_next = S_STREAM;
            end
            S_STREAM: begin
                if (w_hs && w_end) begin
                    w_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = 1'b0;
        clr  = 1'b0;
        done = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_CLEAR: begin
                busy = 1'b1;
                clr  = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Tile configuration captured on an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n      <= 6'd2;
            r_target <= '0;
            r_shift  <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_n      <= w_n_clamp;
            r_target <= target_cnt;
            r_shift  <= shift;
        end
    end

    // Output stage: load origin after settle, advance only on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row   <= '0;
            r_col   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (r_state == S_SETTLE) begin
            r_row   <= '0;
            r_col   <= '0;
            r_data  <= w_q;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
        end else if (r_state == S_STREAM && w_hs) begin
            if (w_end) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_row  <= w_nrow;
                r_col  <= w_ncol;
                r_data <= w_q;
                r_last <= w_nlast;
            end
        end
    end

    assign out_data  = r_data;
    assign out_row   = r_row;
    assign out_col   = r_col;
    assign out_last  = r_last;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: directed table vectors and corner sequences.
// Expected values are hand-computed for the default (signed) build.
module tb_systolic_drain;

    localparam int AS = 16;
    localparam int DW = 8;
    localparam int AW = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic        [5:0]    activated_pe;
    logic        [9:0]    target_cnt;
    logic        [4:0]    shift;
    logic        [9:0]    cnt;
    logic signed [AW-1:0] O [AS][AS];
    logic                 clr;
    logic signed [DW-1:0] out_data;
    logic        [5:0]    out_row;
    logic        [5:0]    out_col;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 done;

    int n_checks = 0;
    int n_err    = 0;

    systolic_drain #(
        .ARRAY_SIZE (AS),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .activated_pe (activated_pe),
        .target_cnt   (target_cnt),
        .shift        (shift),
        .cnt          (cnt),
        .O            (O),
        .clr          (clr),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n_in;
        int sh;
        int acc [4];
        int exp [4];
    } vec_t;

    vec_t tbl [5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int oval(input int r, input int c);
        return r * 16 + c + 1;
    endfunction

    task automatic fill_o;
        for (int r = 0; r < AS; r++)
            for (int c = 0; c < AS; c++)
                O[r][c] = oval(r, c);
    endtask

    task automatic wait_valid(input string tag, output int k);
        k = 0;
        while (!out_valid && k < 50) begin
            tick;
            k++;
        end
        chk({tag, "_valid_timeout"}, out_valid, 1);
    endtask

    task automatic kick(input int n, input int tgt, input int sh);
        activated_pe = 6'(n);
        target_cnt   = 10'(tgt);
        shift        = 5'(sh);
        start        = 1'b1;
        tick;
        start        = 1'b0;
    endtask

    // Ready held high: expect n*n consecutive elements from oval, then clear
    task automatic drain_chk(input int n, input string tag);
        for (int i = 0; i < n * n; i++) begin
            chk($sformatf("%s_v%0d", tag, i), out_valid, 1);
            chk($sformatf("%s_d%0d", tag, i), $signed(out_data), oval(i / n, i % n));
            chk($sformatf("%s_r%0d", tag, i), out_row, i / n);
            chk($sformatf("%s_c%0d", tag, i), out_col, i % n);
            chk($sformatf("%s_l%0d", tag, i), out_last, int'(i == n * n - 1));
            tick;
        end
        chk({tag, "_clr"}, clr, 1);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_vlow"}, out_valid, 0);
        tick;
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int k;
        int bad;
        int idx;
        int cyc;
        int cntv;
        int lr;
        int lc;
        logic rdy;
        logic pv;
        logic pr;
        logic signed [DW-1:0] pd;
        logic [5:0] prow;
        logic [5:0] pcol;
        logic pl;

        tbl[0] = '{2, 0, '{5, -3, 200, -200}, '{5, -3, 127, -128}};
        tbl[1] = '{0, 4, '{24, -24, 7, -8}, '{2, -1, 0, 0}};
`ifdef SYSTOLIC_DRAIN_RELU_EN
        tbl[2] = '{1, 0, '{-50, 300, 127, -129}, '{0, 127, 127, 0}};
        tbl[3] = '{2, 1, '{3, -3, 1, -1}, '{2, 0, 1, 0}};
        tbl[4] = '{2, 8, '{32'h7fffffff, 32'h80000000, 384, -384},
                   '{127, 0, 2, 0}};
`else
        tbl[2] = '{1, 0, '{-50, 300, 127, -129}, '{-50, 127, 127, -128}};
        tbl[3] = '{2, 1, '{3, -3, 1, -1}, '{2, -1, 1, 0}};
        tbl[4] = '{2, 8, '{32'h7fffffff, 32'h80000000, 384, -384},
                   '{127, -128, 2, -1}};
`endif

        rst          = 1'b1;
        start        = 1'b0;
        activated_pe = '0;
        target_cnt   = '0;
        shift        = '0;
        cnt          = '0;
        out_ready    = 1'b0;
        fill_o();
        tick;
        tick;
        tick;
        chk("rst_clr", clr, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", $signed(out_data), 0);
        chk("rst_row", out_row, 0);
        chk("rst_col", out_col, 0);
        rst = 1'b0;
        tick;

        // Table: 2x2 tiles through the requantizer
        out_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            for (int r = 0; r < AS; r++)
                for (int c = 0; c < AS; c++)
                    O[r][c] = '0;
            O[0][0] = tbl[v].acc[0];
            O[0][1] = tbl[v].acc[1];
            O[1][0] = tbl[v].acc[2];
            O[1][1] = tbl[v].acc[3];
            kick(tbl[v].n_in, 0, tbl[v].sh);
            chk($sformatf("t%0d_busy", v), busy, 1);
            wait_valid($sformatf("t%0d", v), k);
            chk($sformatf("t%0d_lat", v), k, 2);
            for (int e = 0; e < 4; e++) begin
                chk($sformatf("t%0d_v%0d", v, e), out_valid, 1);
                chk($sformatf("t%0d_d%0d", v, e), $signed(out_data), tbl[v].exp[e]);
                chk($sformatf("t%0d_r%0d", v, e), out_row, e / 2);
                chk($sformatf("t%0d_c%0d", v, e), out_col, e % 2);
                chk($sformatf("t%0d_l%0d", v, e), out_last, int'(e == 3));
                chk($sformatf("t%0d_nclr%0d", v, e), clr, 0);
                tick;
            end
            chk($sformatf("t%0d_clr", v), clr, 1);
            chk($sformatf("t%0d_done", v), done, 1);
            chk($sformatf("t%0d_vlow", v), out_valid, 0);
            chk($sformatf("t%0d_cbusy", v), busy, 1);
            tick;
            chk($sformatf("t%0d_idle", v), busy, 0);
            chk($sformatf("t%0d_clr0", v), clr, 0);
        end

        // Wait on cnt, with an ignored start while busy
        fill_o();
        cnt = 10'd6;
        kick(4, 7, 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                start        = 1'b1;
                activated_pe = 6'd2;
                target_cnt   = 10'd0;
            end
            tick;
            start = 1'b0;
            if (out_valid) bad++;
        end
        chk("wait_no_valid", bad, 0);
        chk("wait_busy", busy, 1);
        cnt = 10'd7;
        tick;
        chk("wait_settle", out_valid, 0);
        tick;
        chk("wait_first", out_valid, 1);
        drain_chk(4, "w");
        cnt = 10'd0;

        // Backpressure: ready toggles every cycle
        kick(4, 0, 0);
        wait_valid("bp", k);
        idx = 0;
        cyc = 0;
        rdy = 1'b0;
        pv  = 1'b0;
        pr  = 1'b0;
        pd  = '0;
        prow = '0;
        pcol = '0;
        pl  = 1'b0;
        while (!done && cyc < 200) begin
            if (pv && !pr) begin
                chk($sformatf("bp_hold%0d", cyc),
                    int'(out_valid && out_data == pd && out_row == prow &&
                         out_col == pcol && out_last == pl), 1);
            end
            out_ready = rdy;
            if (out_valid && rdy) begin
                chk($sformatf("bp_d%0d", idx), $signed(out_data), oval(idx / 4, idx % 4));
                chk($sformatf("bp_rc%0d", idx), int'(out_row) * 4 + int'(out_col), idx);
                chk($sformatf("bp_l%0d", idx), out_last, int'(idx == 15));
                idx++;
            end
            pv   = out_valid;
            pr   = rdy;
            pd   = out_data;
            prow = out_row;
            pcol = out_col;
            pl   = out_last;
            rdy  = !rdy;
            tick;
            cyc++;
        end
        chk("bp_count", idx, 16);
        chk("bp_done", done, 1);
        out_ready = 1'b1;
        tick;
        chk("bp_idle", busy, 0);

        // Reset in the middle of a stream at element 5
        kick(4, 0, 0);
        wait_valid("mr", k);
        for (int i = 0; i < 5; i++) tick;
        chk("mr_at5", int'(out_row) * 4 + int'(out_col), 5);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mr_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_clr", clr, 0);
        tick;
        chk("mr_still_idle", busy, 0);
        kick(4, 0, 0);
        wait_valid("mr2", k);
        drain_chk(4, "mr2");

        // Oversized window clamps to the full array
        kick(40, 0, 0);
        wait_valid("big", k);
        cntv = 0;
        cyc  = 0;
        lr   = -1;
        lc   = -1;
        while (!done && cyc < 400) begin
            if (out_valid) begin
                if (out_last) begin
                    lr = int'(out_row);
                    lc = int'(out_col);
                end
                cntv++;
            end
            tick;
            cyc++;
        end
        chk("big_count", cntv, 256);
        chk("big_last_row", lr, 15);
        chk("big_last_col", lc, 15);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
